// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a 16-bit multicycle datapath
//   in : clk, Clear_n (async active-low), opcode[3:0] (Instr[15:12]), zero, mem_ready, run
//   out: IRWrite, PCWrite, RegDst, RegWrite, ALU_src, MemRead, MemWrite, MemToReg,
//        PC_src[1:0], ALU_op[1:0], state[2:0], halted, illegal, instr_count[15:0]
module multicycle_ctrl (
   input  logic        clk,
   input  logic        Clear_n,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   input  logic        run,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALU_src,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemToReg,
   output logic [1:0]  PC_src,
   output logic [1:0]  ALU_op,
   output logic [2:0]  state,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instr_count
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5,
      ERR    = 3'd6
   } state_t;
   localparam logic [3:0] OP_R    = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h2;
   localparam logic [3:0] OP_SW   = 4'h3;
   localparam logic [3:0] OP_BEQ  = 4'h4;
   localparam logic [3:0] OP_J    = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;
   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [15:0] cnt_q, cnt_d;
   logic        en_q;
   logic        retire;
   // en_q holds all strobes low and freezes the FSM until the first clock edge after reset release
   always_ff @(posedge clk or negedge Clear_n) begin
      if (!Clear_n) begin
         state_q <= FETCH;
         op_q    <= '0;
         wcnt_q  <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wcnt_q  <= wcnt_d;
         cnt_q   <= cnt_d;
         en_q    <= 1'b1;
      end
   end
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALU_src  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemToReg = 1'b0;
      PC_src   = 2'b00;
      ALU_op   = 2'b00;
      if (en_q) begin
         case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               state_d = mem_ready ? DECODE : (wcnt_q == 8'hFF) ? ERR : FETCH;
            end
            DECODE: begin
               op_d    = opcode;
               state_d = (opcode == OP_HALT) ? HALT : (opcode <= OP_J) ? EXEC : ERR;
            end
            EXEC: begin
               case (op_q)
                  OP_R: begin
                     ALU_op  = 2'b10;
                     state_d = WB;
                  end
                  OP_ADDI: begin
                     ALU_src = 1'b1;
                     state_d = WB;
                  end
                  OP_LW, OP_SW: begin
                     ALU_src = 1'b1;
                     state_d = MEM;
                  end
                  OP_BEQ: begin
                     ALU_op  = 2'b01;
                     PC_src  = 2'b01;
                     PCWrite = zero;
                     state_d = FETCH;
                  end
                  OP_J: begin
                     PCWrite = 1'b1;
                     PC_src  = 2'b10;
                     state_d = FETCH;
                  end
                  default: state_d = ERR;
               endcase
            end
            MEM: begin
               MemRead  = (op_q == OP_LW);
               MemWrite = (op_q == OP_SW);
               state_d  = mem_ready ? ((op_q == OP_LW) ? WB : FETCH) : (wcnt_q == 8'hFF) ? ERR : MEM;
            end
            WB: begin
               RegWrite = 1'b1;
               RegDst   = (op_q == OP_R);
               MemToReg = (op_q == OP_LW);
               state_d  = FETCH;
            end
            HALT:    state_d = run ? FETCH : HALT;
            ERR:     state_d = ERR;
            default: state_d = ERR;
         endcase
      end
   end
   // staying in FETCH/MEM implies mem_ready was low, so any non-transition there is a wait cycle
   assign wcnt_d = (state_d != state_q) ? 8'd0
                 : wcnt_q + {7'd0, en_q && (state_q == FETCH || state_q == MEM)};
   assign retire = (state_d == FETCH) && (state_q == EXEC || state_q == MEM || state_q == WB);
   assign cnt_d  = cnt_q + {15'd0, retire};
   assign state       = state_q;
   assign halted      = (state_q == HALT);
   assign illegal     = (state_q == ERR);
   assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level trace model checked against multicycle_ctrl every cycle
module tb_multicycle_ctrl;
   logic clk = 1'b0, Clear_n = 1'b0, zero = 1'b0, mem_ready = 1'b0, run = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic IRWrite, PCWrite, RegDst, RegWrite, ALU_src, MemRead, MemWrite, MemToReg, halted, illegal;
   logic [1:0] PC_src, ALU_op;
   logic [2:0] state;
   logic [15:0] instr_count;
   always #5 clk = ~clk;
   multicycle_ctrl dut (
      .clk(clk), .Clear_n(Clear_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .run(run),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALU_src(ALU_src),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .PC_src(PC_src), .ALU_op(ALU_op),
      .state(state), .halted(halted), .illegal(illegal), .instr_count(instr_count)
   );
   localparam logic [7:0] IRW = 8'h80, PCW = 8'h40, RD = 8'h20, RW = 8'h10;
   localparam logic [7:0] AS = 8'h08, MR = 8'h04, MW = 8'h02, M2R = 8'h01;
   localparam logic [3:0] XOP = 4'hA;
   typedef struct {
      logic cn, ld, z, mr, rn;
      logic [3:0] op;
      logic [2:0] st;
      logic [7:0] sb;
      logic [1:0] pcs, alu;
      logic [15:0] cnt;
   } vec_t;
   vec_t q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic [15:0] m_cnt = 16'h0;
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask
   task automatic put(input logic cn, input logic ld, input logic [3:0] op, input logic z,
                      input logic mr, input logic rn, input logic [2:0] st, input logic [7:0] sb,
                      input logic [1:0] pcs, input logic [1:0] alu);
      vec_t v;
      if (ld) m_cnt = 16'hFFFF;
      v.cn = cn; v.ld = ld; v.op = op; v.z = z; v.mr = mr; v.rn = rn;
      v.st = st; v.sb = sb; v.pcs = pcs; v.alu = alu; v.cnt = m_cnt;
      q.push_back(v);
   endtask
   task automatic do_reset();
      m_cnt = 16'h0;
      put(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'd0, 2'd0);
      put(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'd0, 2'd0);
   endtask
   // fw wait cycles, then the fetch completes and DECODE samples op
   task automatic fetch(input int fw, input logic [3:0] op, input logic ld);
      for (int i = 0; i < fw; i++)
         put(1'b1, ld && i == 0, op, 1'b0, 1'b0, 1'b0, 3'd0, MR, 2'd0, 2'd0);
      put(1'b1, ld && fw == 0, op, 1'b0, 1'b1, 1'b0, 3'd0, MR | IRW | PCW, 2'd0, 2'd0);
      put(1'b1, 1'b0, op, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 2'd0, 2'd0);
   endtask
   // one whole instruction; mw = memory wait cycles (or HALT/ERR dwell cycles)
   task automatic instr(input logic [3:0] op, input int fw, input int mw, input logic z, input logic ld);
      fetch(fw, op, ld);
      case (op)
         4'h0: begin
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 2'd0, 2'd2);
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd4, RW | RD, 2'd0, 2'd0);
            m_cnt++;
         end
         4'h1: begin
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd2, AS, 2'd0, 2'd0);
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd4, RW, 2'd0, 2'd0);
            m_cnt++;
         end
         4'h2, 4'h3: begin
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd2, AS, 2'd0, 2'd0);
            for (int i = 0; i <= mw; i++)
               put(1'b1, 1'b0, XOP, 1'b0, i == mw, 1'b0, 3'd3, op == 4'h2 ? MR : MW, 2'd0, 2'd0);
            if (op == 4'h2) put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd4, RW | M2R, 2'd0, 2'd0);
            m_cnt++;
         end
         4'h4: begin
            put(1'b1, 1'b0, XOP, z, 1'b0, 1'b0, 3'd2, z ? PCW : 8'h00, 2'd1, 2'd1);
            m_cnt++;
         end
         4'h5: begin
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd2, PCW, 2'd2, 2'd0);
            m_cnt++;
         end
         4'hF: begin
            for (int i = 0; i < mw; i++)
               put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 2'd0, 2'd0);
            put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 2'd0, 2'd0);
         end
         default:
            for (int i = 0; i < mw; i++)
               put(1'b1, 1'b0, XOP, 1'b0, i[0], 1'b1, 3'd6, 8'h00, 2'd0, 2'd0);
      endcase
   endtask
   task automatic play();
      vec_t v;
      while (q.size() > 0) begin
         v = q.pop_front();
         @(posedge clk);
         #1;
         if (v.ld) begin
            force dut.cnt_q = 16'hFFFF;
            #1 release dut.cnt_q;
         end
         Clear_n = v.cn; opcode = v.op; zero = v.z; mem_ready = v.mr; run = v.rn;
         @(negedge clk);
         cyc++;
         chk("state", {13'd0, state}, {13'd0, v.st});
         chk("strobes", {8'd0, IRWrite, PCWrite, RegDst, RegWrite, ALU_src, MemRead, MemWrite, MemToReg},
             {8'd0, v.sb});
         chk("PC_src", {14'd0, PC_src}, {14'd0, v.pcs});
         chk("ALU_op", {14'd0, ALU_op}, {14'd0, v.alu});
         chk("halted", {15'd0, halted}, {15'd0, v.st == 3'd5});
         chk("illegal", {15'd0, illegal}, {15'd0, v.st == 3'd6});
         chk("instr_count", instr_count, v.cnt);
      end
   endtask
   initial begin
      do_reset(); instr(4'h0, 0, 0, 1'b0, 1'b0); play();
      chk("lit_rtype_state", {13'd0, state}, 16'd4);
      chk("lit_rtype_regdst", {15'd0, RegDst}, 16'd1);
      chk("lit_rtype_cnt", instr_count, 16'd0);
      instr(4'h1, 2, 0, 1'b0, 1'b0); play();
      chk("lit_addi_cnt", instr_count, 16'd1);
      instr(4'h2, 0, 3, 1'b0, 1'b0); play();
      chk("lit_lw_memtoreg", {15'd0, MemToReg}, 16'd1);
      chk("lit_lw_cnt", instr_count, 16'd2);
      instr(4'h3, 1, 2, 1'b0, 1'b0);
      instr(4'h4, 0, 0, 1'b1, 1'b0); play();
      chk("lit_beq1_pcwrite", {15'd0, PCWrite}, 16'd1);
      chk("lit_beq1_pcsrc", {14'd0, PC_src}, 16'd1);
      chk("lit_beq1_cnt", instr_count, 16'd4);
      instr(4'h4, 0, 0, 1'b0, 1'b0); play();
      chk("lit_beq0_pcwrite", {15'd0, PCWrite}, 16'd0);
      instr(4'h5, 0, 0, 1'b0, 1'b0); play();
      chk("lit_j_pcsrc", {14'd0, PC_src}, 16'd2);
      chk("lit_j_cnt", instr_count, 16'd6);
      instr(4'hF, 0, 3, 1'b0, 1'b0); play();
      chk("lit_halt_halted", {15'd0, halted}, 16'd1);
      chk("lit_halt_cnt", instr_count, 16'd7);
      instr(4'h0, 255, 0, 1'b0, 1'b0); play();
      chk("lit_late_ready_cnt", instr_count, 16'd7);
      instr(4'h0, 0, 0, 1'b0, 1'b1);
      instr(4'h1, 0, 0, 1'b0, 1'b0); play();
      chk("lit_wrap_cnt", instr_count, 16'h0000);
      fetch(0, 4'h3, 1'b0);
      put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd2, AS, 2'd0, 2'd0);
      put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd3, MW, 2'd0, 2'd0);
      put(1'b1, 1'b0, XOP, 1'b0, 1'b0, 1'b0, 3'd3, MW, 2'd0, 2'd0);
      do_reset(); play();
      chk("lit_midreset_state", {13'd0, state}, 16'd0);
      chk("lit_midreset_memwrite", {15'd0, MemWrite}, 16'd0);
      chk("lit_midreset_cnt", instr_count, 16'd0);
      for (int i = 0; i < 256; i++)
         put(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, MR, 2'd0, 2'd0);
      for (int i = 0; i < 3; i++)
         put(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd6, 8'h00, 2'd0, 2'd0);
      play();
      chk("lit_timeout_illegal", {15'd0, illegal}, 16'd1);
      do_reset(); instr(4'hA, 0, 4, 1'b0, 1'b0); play();
      chk("lit_illegal_state", {13'd0, state}, 16'd6);
      chk("lit_illegal_cnt", instr_count, 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
